dual_port_mem_responder: RTL and testbench

Responder end of the CPU's split instruction/data memory interfaces: serves the instruction-fetch read port and the data read/write port from one single-ported word array with a fixed, parameterised latency. It sits outside the pipelined CPU in the top-level system and the bench. Both ports follow the same level-request protocol: the request is held until a one-cycle `resp` pulse. One transaction is in flight at a time, and simultaneous requests are arbitrated round-robin.

---
 rtl/dual_port_mem_responder.sv | 110 +++++++++++
 tb/tb_dual_port_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_mem_responder.sv
// dual_port_mem_responder: fixed-latency responder for split instruction/data memory ports
//   clk, reset              : clock, asynchronous active-high reset
//   i_mem_read/address      : instruction read request (level), byte address
//   i_mem_resp/rdata        : one-cycle completion pulse, read word (0 when idle)
//   d_mem_read/write        : data request (level); write wins when both are set
//   d_mem_address/wdata/byte_enable : data byte address, write word, byte mask
//   d_mem_resp/rdata        : one-cycle completion pulse, read word (0 when idle or write)
module dual_port_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mem_read,
  input  logic [15:0] i_mem_address,
  output logic        i_mem_resp,
  output logic [15:0] i_mem_rdata,
  input  logic        d_mem_read,
  input  logic        d_mem_write,
  input  logic [15:0] d_mem_address,
  input  logic [15:0] d_mem_wdata,
  input  logic [1:0]  d_mem_byte_enable,
  output logic        d_mem_resp,
  output logic [15:0] d_mem_rdata
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  logic [1:0]            r_state;
  logic                  r_gnt;
  logic                  r_last;
  logic [3:0]            r_cnt;
  logic                  r_i_resp;
  logic                  r_d_resp;
  logic [15:0]           r_i_rdata;
  logic [15:0]           r_d_rdata;
  logic [15:0]           r_mem [2**ADDR_WIDTH];
  logic                  w_d_req;
  logic                  w_req;
  logic                  w_pick;
  logic                  w_done;
  logic                  w_wr;
  logic [15:0]           w_addr;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [15:0]           w_old;
  logic [15:0]           w_new;
  logic                  w_unused;
  assign w_d_req = d_mem_read | d_mem_write;
  // r_gnt: 0 = instruction port, 1 = data port
  assign w_req   = r_gnt ? w_d_req : i_mem_read;
  // on a tie the port not served last wins
  assign w_pick  = (i_mem_read && w_d_req) ? ~r_last : w_d_req;
  // completion edge: request still held and latency expired
  assign w_done  = (r_state == S_BUSY) && w_req && (r_cnt == 4'd0);
  assign w_addr  = r_gnt ? d_mem_address : i_mem_address;
  assign w_idx   = w_addr[ADDR_WIDTH:1];
  assign w_wr    = r_gnt && d_mem_write;
  assign w_old   = r_mem[w_idx];
  assign w_new   = {d_mem_byte_enable[1] ? d_mem_wdata[15:8] : w_old[15:8],
                    d_mem_byte_enable[0] ? d_mem_wdata[7:0]  : w_old[7:0]};
  assign w_unused = ^{w_addr[0], w_addr[15:ADDR_WIDTH+1]};
  assign i_mem_resp  = r_i_resp;
  assign i_mem_rdata = r_i_rdata;
  assign d_mem_resp  = r_d_resp;
  assign d_mem_rdata = r_d_rdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gnt     <= 1'b0;
      r_last    <= 1'b0;
      r_cnt     <= 4'd0;
      r_i_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
      r_i_rdata <= 16'h0000;
      r_d_rdata <= 16'h0000;
    end else begin
      r_i_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
      r_i_rdata <= 16'h0000;
      r_d_rdata <= 16'h0000;
      if (r_state == S_IDLE) begin
        if (i_mem_read || w_d_req) begin
          r_state <= S_BUSY;
          r_gnt   <= w_pick;
          r_cnt   <= 4'(LATENCY - 1);
        end
      end else if (r_state == S_BUSY) begin
        if (!w_req) begin
          r_state <= S_IDLE;
        end else if (w_done) begin
          r_state   <= S_RESP;
          r_i_resp  <= ~r_gnt;
          r_d_resp  <= r_gnt;
          r_i_rdata <= r_gnt ? 16'h0000 : w_old;
          r_d_rdata <= (r_gnt && !w_wr) ? w_old : 16'h0000;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end else begin
        r_state <= S_IDLE;
        r_last  <= r_gnt;
      end
    end
  end
  // array is not reset; a write lands on the same edge that raises resp
  always_ff @(posedge clk) begin
    if (w_done && w_wr)
      r_mem[w_idx] <= w_new;
  end
endmodule

// File: tb/tb_dual_port_mem_responder.sv
// tb_dual_port_mem_responder: scoreboard bench for dual_port_mem_responder
module tb_dual_port_mem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_mem_read = 1'b0;
  logic [15:0] i_mem_address = 16'h0;
  logic        i_mem_resp;
  logic [15:0] i_mem_rdata;
  logic        d_mem_read = 1'b0;
  logic        d_mem_write = 1'b0;
  logic [15:0] d_mem_address = 16'h0;
  logic [15:0] d_mem_wdata = 16'h0;
  logic [1:0]  d_mem_byte_enable = 2'b00;
  logic        d_mem_resp;
  logic [15:0] d_mem_rdata;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [47:0] exp_i[$];
  logic [47:0] exp_d[$];
  logic [47:0] ei;
  logic [47:0] ed;

  dual_port_mem_responder dut (
    .clk(clk), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_byte_enable(d_mem_byte_enable),
    .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every response is popped against the expectation pushed at stimulus time
  always @(negedge clk) begin
    n_chk++;
    if (i_mem_resp) begin
      if (exp_i.size() == 0) begin
        n_fail++;
        $display("FAIL i_resp_unexpected: got pulse at cycle %0d data %h, required none", cyc, i_mem_rdata);
      end else begin
        ei = exp_i.pop_front();
        if ({32'(cyc), i_mem_rdata} !== ei) begin
          n_fail++;
          $display("FAIL i_resp: got cycle %0d data %h, required cycle %0d data %h", cyc, i_mem_rdata, ei[47:16], ei[15:0]);
        end
      end
    end else if (i_mem_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL i_rdata_idle: got %h, required 0000", i_mem_rdata);
    end
    n_chk++;
    if (d_mem_resp) begin
      if (exp_d.size() == 0) begin
        n_fail++;
        $display("FAIL d_resp_unexpected: got pulse at cycle %0d data %h, required none", cyc, d_mem_rdata);
      end else begin
        ed = exp_d.pop_front();
        if ({32'(cyc), d_mem_rdata} !== ed) begin
          n_fail++;
          $display("FAIL d_resp: got cycle %0d data %h, required cycle %0d data %h", cyc, d_mem_rdata, ed[47:16], ed[15:0]);
        end
      end
    end else if (d_mem_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL d_rdata_idle: got %h, required 0000", d_mem_rdata);
    end
  end

  task automatic d_op(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                      input logic [1:0] be, input logic [15:0] exp);
    int k = 0;
    @(negedge clk);
    d_mem_read = !wr;
    d_mem_write = wr;
    d_mem_address = a;
    d_mem_wdata = wd;
    d_mem_byte_enable = be;
    exp_d.push_back({32'(cyc + 3), exp});
    do begin
      @(negedge clk);
      k++;
    end while (!d_mem_resp && k < 20);
    n_chk++;
    if (!d_mem_resp) begin
      n_fail++;
      $display("FAIL d_timeout: got no d_mem_resp within %0d cycles for addr %h, required a pulse", k, a);
    end
    d_mem_read = 1'b0;
    d_mem_write = 1'b0;
  endtask

  task automatic i_op(input logic [15:0] a, input logic [15:0] exp);
    int k = 0;
    @(negedge clk);
    i_mem_read = 1'b1;
    i_mem_address = a;
    exp_i.push_back({32'(cyc + 3), exp});
    do begin
      @(negedge clk);
      k++;
    end while (!i_mem_resp && k < 20);
    n_chk++;
    if (!i_mem_resp) begin
      n_fail++;
      $display("FAIL i_timeout: got no i_mem_resp within %0d cycles for addr %h, required a pulse", k, a);
    end
    i_mem_read = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk += 4;
    if (i_mem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_i_resp: got %b, required 0", i_mem_resp); end
    if (d_mem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_d_resp: got %b, required 0", d_mem_resp); end
    if (i_mem_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_i_rdata: got %h, required 0000", i_mem_rdata); end
    if (d_mem_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_d_rdata: got %h, required 0000", d_mem_rdata); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    d_op(1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000);
    d_op(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF);
    @(negedge clk);
    n_chk++;
    if (exp_d.size() != 0) begin n_fail++; $display("FAIL write_read_pending: got %0d outstanding, required 0", exp_d.size()); end
  endtask

  task automatic test_byte_mask();
    d_op(1'b1, 16'h0010, 16'h1234, 2'b01, 16'h0000);
    d_op(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBE34);
    d_op(1'b1, 16'h0010, 16'hAA55, 2'b10, 16'h0000);
    d_op(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hAA34);
    d_op(1'b1, 16'h0010, 16'hFFFF, 2'b00, 16'h0000);
    d_op(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hAA34);
    @(negedge clk);
    n_chk++;
    if (exp_d.size() != 0) begin n_fail++; $display("FAIL byte_mask_pending: got %0d outstanding, required 0", exp_d.size()); end
  endtask

  task automatic test_arbitration();
    int c;
    d_op(1'b1, 16'h0020, 16'h1111, 2'b11, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      c = cyc;
      i_mem_read = 1'b1;
      i_mem_address = 16'h0010;
      d_mem_read = 1'b1;
      d_mem_address = 16'h0020;
      exp_d.push_back({32'(c + 3), 16'h1111});
      exp_i.push_back({32'(c + 7), 16'hAA34});
      repeat (7) @(negedge clk);
      i_mem_read = 1'b0;
      d_mem_read = 1'b0;
    end
    @(negedge clk);
    n_chk += 2;
    if (exp_d.size() != 0) begin n_fail++; $display("FAIL arb_d_pending: got %0d outstanding, required 0", exp_d.size()); end
    if (exp_i.size() != 0) begin n_fail++; $display("FAIL arb_i_pending: got %0d outstanding, required 0", exp_i.size()); end
  endtask

  task automatic test_abort();
    int c;
    int k = 0;
    @(negedge clk);
    c = cyc;
    d_mem_read = 1'b1;
    d_mem_address = 16'h0010;
    @(negedge clk);
    d_mem_read = 1'b0;
    i_mem_read = 1'b1;
    i_mem_address = 16'h0010;
    exp_i.push_back({32'(c + 5), 16'hAA34});
    do begin
      @(negedge clk);
      k++;
    end while (!i_mem_resp && k < 20);
    i_mem_read = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (exp_i.size() != 0) begin n_fail++; $display("FAIL abort_i_pending: got %0d outstanding, required 0", exp_i.size()); end
  endtask

  task automatic test_alias();
    d_op(1'b1, 16'h0200, 16'h5A5A, 2'b11, 16'h0000);
    d_op(1'b0, 16'h0000, 16'h0000, 2'b00, 16'h5A5A);
    i_op(16'h0201, 16'h5A5A);
    @(negedge clk);
    n_chk += 2;
    if (exp_d.size() != 0) begin n_fail++; $display("FAIL alias_d_pending: got %0d outstanding, required 0", exp_d.size()); end
    if (exp_i.size() != 0) begin n_fail++; $display("FAIL alias_i_pending: got %0d outstanding, required 0", exp_i.size()); end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    d_mem_read = 1'b1;
    d_mem_address = 16'h0010;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk += 4;
    if (i_mem_resp !== 1'b0) begin n_fail++; $display("FAIL busy_reset_i_resp: got %b, required 0", i_mem_resp); end
    if (d_mem_resp !== 1'b0) begin n_fail++; $display("FAIL busy_reset_d_resp: got %b, required 0", d_mem_resp); end
    if (i_mem_rdata !== 16'h0) begin n_fail++; $display("FAIL busy_reset_i_rdata: got %h, required 0000", i_mem_rdata); end
    if (d_mem_rdata !== 16'h0) begin n_fail++; $display("FAIL busy_reset_d_rdata: got %h, required 0000", d_mem_rdata); end
    d_mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    d_mem_write = 1'b1;
    d_mem_address = 16'h0010;
    d_mem_wdata = 16'hDEAD;
    d_mem_byte_enable = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    d_mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    d_op(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hAA34);
    @(negedge clk);
    n_chk++;
    if (exp_d.size() != 0) begin n_fail++; $display("FAIL busy_reset_pending: got %0d outstanding, required 0", exp_d.size()); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_arbitration();
    test_abort();
    test_alias();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
